audio_sample_scheduler: RTL and testbench

AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

---
 rtl/audio_sample_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// -----------------------------------------------------------------------------
// audio_sample_scheduler
//
// Paces a stereo audio stream into an HDMI encoder at SAMPLE_HZ using a
// drift-free phase accumulator clocked at CLK_HZ. A one-entry pending buffer
// sits between the producer handshake and the encoder-facing sample word.
//
// Parameters
//   CLK_HZ     frequency of clk in Hz
//   SAMPLE_HZ  audio sample rate in Hz (must be below CLK_HZ/2)
//   WIDTH      bits per channel sample
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   enable          run request; low stops ticks and flushes the buffer
//   in_valid        producer has a sample on in_left/in_right
//   in_left         left channel sample
//   in_right        right channel sample
//   in_ready        registered; a sample transfers when in_valid && in_ready
//   audio_word      current sample word {left, right}
//   sample_tick     one-cycle pulse per sample period
//   audio_clk       sample-rate waveform, high for CLK_HZ/(2*SAMPLE_HZ) cycles
//   underrun        one-cycle pulse when a tick finds the buffer empty
//   underrun_count  saturating underrun count
//
// Build option
//   AUDIO_UNDERRUN_COUNT_EN  defined: underrun_count counts underrun pulses,
//                            saturating at 16'hFFFF. Undefined: tied to 0.
// -----------------------------------------------------------------------------
module audio_sample_scheduler #(
    parameter int CLK_HZ    = 100000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int WIDTH     = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_left,
    input  logic [WIDTH-1:0]     in_right,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   audio_word,
    output logic                 sample_tick,
    output logic                 audio_clk,
    output logic                 underrun,
    output logic [15:0]          underrun_count
);

    // One extra bit so acc + SAMPLE_HZ never overflows before the compare.
    localparam int ACC_W       = $clog2(CLK_HZ) + 1;
    localparam int HIGH_RAW    = CLK_HZ / (2 * SAMPLE_HZ);
    localparam int HIGH_CYCLES = (HIGH_RAW < 1) ? 1 : HIGH_RAW;
    localparam int HC_W        = $clog2(HIGH_CYCLES + 1);

    localparam logic [ACC_W-1:0] STEP    = ACC_W'(SAMPLE_HZ);
    localparam logic [ACC_W-1:0] PERIOD  = ACC_W'(CLK_HZ);
    // The tick cycle itself is the first high cycle; the counter holds the rest.
    localparam logic [HC_W-1:0]  HC_LOAD = HC_W'(HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t              state, state_nx;
    logic [ACC_W-1:0]    acc, acc_nx, acc_sum;
    logic [2*WIDTH-1:0]  pend_word, pend_word_nx;
    logic                pend_full, pend_full_nx;
    logic [2*WIDTH-1:0]  audio_word_nx;
    logic [HC_W-1:0]     hc_cnt, hc_cnt_nx;
    logic                in_ready_nx;
    logic                tick_nx;
    logic                underrun_nx;
    logic                audio_clk_nx;
    logic                xfer;
    logic                wrap;

    assign xfer    = in_valid & in_ready;
    assign acc_sum = acc + STEP;
    assign wrap    = (state == ST_RUN) && (acc_sum >= PERIOD);

    // NOTE: every variable gets its default before any branch so a missed
    // assignment in some path can never infer a latch.
    always_comb begin
        state_nx      = state;
        acc_nx        = acc;
        pend_word_nx  = pend_word;
        pend_full_nx  = pend_full;
        audio_word_nx = audio_word;
        hc_cnt_nx     = '0;
        tick_nx       = 1'b0;
        underrun_nx   = 1'b0;
        audio_clk_nx  = 1'b0;

        if (!enable) begin
            // Leaving the run: pulses are truncated, buffer flushed, word held.
            state_nx     = ST_OFF;
            acc_nx       = '0;
            pend_full_nx = 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nx     = ST_PRIME;
                    acc_nx       = '0;
                    pend_full_nx = 1'b0;
                end
                ST_PRIME: begin
                    acc_nx = '0;
                    // First sample bypasses the buffer so the encoder has
                    // valid data before the first tick.
                    if (xfer) begin
                        audio_word_nx = {in_left, in_right};
                        state_nx      = ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_nx = wrap ? (acc_sum - PERIOD) : acc_sum;

                    if (wrap) begin
                        audio_clk_nx = 1'b1;
                        hc_cnt_nx    = HC_LOAD;
                    end else if (hc_cnt != '0) begin
                        audio_clk_nx = 1'b1;
                        hc_cnt_nx    = hc_cnt - 1'b1;
                    end

                    if (wrap) begin
                        tick_nx = 1'b1;
                        if (pend_full) begin
                            audio_word_nx = pend_word;
                            pend_full_nx  = 1'b0;
                        end else begin
                            underrun_nx = 1'b1;
                        end
                    end

                    // in_ready is low while the buffer is full, so a transfer
                    // only ever lands in an empty buffer; when it coincides
                    // with an underrun tick it waits for the next tick.
                    if (xfer) begin
                        pend_word_nx = {in_left, in_right};
                        pend_full_nx = 1'b1;
                    end
                end
                default: state_nx = ST_OFF;
            endcase
        end

        in_ready_nx = (state_nx != ST_OFF) && !pend_full_nx;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            acc         <= '0;
            // NOTE: the buffer contents are qualified by pend_full, but they
            // are cleared too so nothing X ever reaches audio_word.
            pend_word   <= '0;
            pend_full   <= 1'b0;
            audio_word  <= '0;
            hc_cnt      <= '0;
            in_ready    <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            audio_clk   <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            pend_word   <= pend_word_nx;
            pend_full   <= pend_full_nx;
            audio_word  <= audio_word_nx;
            hc_cnt      <= hc_cnt_nx;
            in_ready    <= in_ready_nx;
            sample_tick <= tick_nx;
            underrun    <= underrun_nx;
            audio_clk   <= audio_clk_nx;
        end
    end

`ifdef AUDIO_UNDERRUN_COUNT_EN
    // Counts on the same edge that raises the underrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (underrun_nx && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_scheduler.sv
`timescale 1ns/1ps
module tb_audio_sample_scheduler;

    localparam int W = 8;

`ifdef AUDIO_UNDERRUN_COUNT_EN
    localparam int EXP_UR = 5;
`else
    localparam int EXP_UR = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: CLK_HZ=10, SAMPLE_HZ=3
    logic           enable   = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_left  = '0;
    logic [W-1:0]   in_right = '0;
    logic           in_ready;
    logic [2*W-1:0] audio_word;
    logic           sample_tick, audio_clk, underrun;
    logic [15:0]    underrun_count;

    audio_sample_scheduler #(.CLK_HZ(10), .SAMPLE_HZ(3), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
        .audio_word(audio_word), .sample_tick(sample_tick), .audio_clk(audio_clk),
        .underrun(underrun), .underrun_count(underrun_count)
    );

    // Rate instance: CLK_HZ=1000, SAMPLE_HZ=48 -> 48 ticks/1000 cycles, 10-cycle pulses
    logic           r_enable   = 1'b0;
    logic           r_in_valid = 1'b0;
    logic [W-1:0]   r_in_left  = 8'h3C;
    logic [W-1:0]   r_in_right = 8'hC3;
    logic           r_in_ready;
    logic [2*W-1:0] r_audio_word;
    logic           r_sample_tick, r_audio_clk, r_underrun;
    logic [15:0]    r_underrun_count;

    audio_sample_scheduler #(.CLK_HZ(1000), .SAMPLE_HZ(48), .WIDTH(W)) u_rate (
        .clk(clk), .rst_n(rst_n), .enable(r_enable), .in_valid(r_in_valid),
        .in_left(r_in_left), .in_right(r_in_right), .in_ready(r_in_ready),
        .audio_word(r_audio_word), .sample_tick(r_sample_tick), .audio_clk(r_audio_clk),
        .underrun(r_underrun), .underrun_count(r_underrun_count)
    );

    int checks = 0;
    int passed = 0;

    // Scoreboard: accepted samples are queued when the handshake completes and
    // popped when a tick should load them into audio_word.
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_w;
    logic [2*W-1:0] pend_w;
    logic [2*W-1:0] prime_w;
    logic [2*W-1:0] last_word = '0;
    bit             sb_on      = 1'b0;
    bit             primed     = 1'b0;
    bit             pend_v     = 1'b0;
    bit             pend_prime = 1'b0;
    int             cyc        = 0;
    int             n_ticks    = 0;
    int             n_underruns = 0;
    int             tick_cyc[$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_on) begin
                if (pend_prime) begin
                    checks++;
                    if (audio_word !== prime_w)
                        $display("FAIL prime_word: audio_word=%h expected %h", audio_word, prime_w);
                    else passed++;
                    last_word  = prime_w;
                    pend_prime = 1'b0;
                    tick_cyc.push_back(cyc);
                end
                if (sample_tick) begin
                    n_ticks++;
                    tick_cyc.push_back(cyc);
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        checks++;
                        if (underrun !== 1'b0 || audio_word !== exp_w)
                            $display("FAIL tick_load: underrun=%b audio_word=%h expected underrun=0 word=%h",
                                     underrun, audio_word, exp_w);
                        else passed++;
                        last_word = exp_w;
                    end else begin
                        n_underruns++;
                        checks++;
                        if (underrun !== 1'b1 || audio_word !== last_word)
                            $display("FAIL tick_underrun: underrun=%b audio_word=%h expected underrun=1 word=%h",
                                     underrun, audio_word, last_word);
                        else passed++;
                    end
                end else begin
                    checks++;
                    if (underrun !== 1'b0 || audio_word !== last_word)
                        $display("FAIL idle_hold: underrun=%b audio_word=%h expected underrun=0 word=%h",
                                 underrun, audio_word, last_word);
                    else passed++;
                end
                if (pend_v) exp_q.push_back(pend_w);
                pend_v = 1'b0;
                if (in_valid && in_ready) begin
                    if (!primed) begin
                        primed     = 1'b1;
                        pend_prime = 1'b1;
                        prime_w    = {in_left, in_right};
                    end else begin
                        pend_v = 1'b1;
                        pend_w = {in_left, in_right};
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, sample_tick, audio_clk, underrun} !== 4'b0000)
            $display("FAIL reset_flags: {in_ready,tick,aclk,underrun}=%b expected 0000",
                     {in_ready, sample_tick, audio_clk, underrun});
        else passed++;
        checks++;
        if (audio_word !== 16'h0000 || underrun_count !== 16'h0000)
            $display("FAIL reset_data: audio_word=%h underrun_count=%h expected 0000/0000",
                     audio_word, underrun_count);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL off_ready: in_ready=%b expected 0", in_ready);
        else passed++;
    endtask

    task automatic test_prime_idle();
        int ticks = 0;
        int pulses = 0;
        @(posedge clk); #1; enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sample_tick) ticks++;
            if (audio_clk || underrun) pulses++;
        end
        #1;
        checks++;
        if (ticks != 0 || pulses != 0)
            $display("FAIL prime_no_tick: ticks=%0d pulses=%0d expected 0/0", ticks, pulses);
        else passed++;
        checks++;
        if (in_ready !== 1'b1 || audio_word !== 16'h0000)
            $display("FAIL prime_state: in_ready=%b audio_word=%h expected 1/0000", in_ready, audio_word);
        else passed++;
    endtask

    task automatic test_stream();
        bit accepted;
        int k = 0;
        int bad = 0;
        int d;
        exp_q.delete(); tick_cyc.delete();
        n_ticks = 0; n_underruns = 0; primed = 1'b0; last_word = 16'h0000;
        sb_on = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_left = 8'h11; in_right = 8'h22;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) begin
                k++;
                in_left  = 8'(8'h11 + k);
                in_right = 8'(8'h22 + k);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (tick_cyc.size() < 10)
            $display("FAIL stream_ticks: events=%0d expected at least 10", tick_cyc.size());
        else passed++;
        for (int i = 1; i < tick_cyc.size(); i++) begin
            d = tick_cyc[i] - tick_cyc[i-1];
            if (d != (((i % 3) == 1) ? 4 : 3)) bad++;
        end
        checks++;
        if (bad != 0)
            $display("FAIL stream_interval: bad_intervals=%0d expected 0 (pattern 4,3,3)", bad);
        else passed++;
        checks++;
        if (n_underruns != 0)
            $display("FAIL stream_underrun: underruns=%0d expected 0", n_underruns);
        else passed++;
    endtask

    task automatic test_underrun();
        int guard = 0;
        while (n_underruns < 5 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (n_underruns != 5)
            $display("FAIL underrun_seen: underruns=%0d expected 5", n_underruns);
        else passed++;
        checks++;
        if (underrun_count !== 16'(EXP_UR))
            $display("FAIL underrun_count: got %0d expected %0d", underrun_count, EXP_UR);
        else passed++;
        checks++;
        if (audio_word !== last_word)
            $display("FAIL underrun_hold: audio_word=%h expected %h", audio_word, last_word);
        else passed++;
    endtask

    task automatic wait_tick(input string name);
        int guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!sample_tick && guard < 20);
        checks++;
        if (!sample_tick)
            $display("FAIL %s: sample_tick=%b expected 1 within 20 cycles", name, sample_tick);
        else passed++;
    endtask

    task automatic test_collision();
        int d;
        wait_tick("collide_wait");
        d = ((n_ticks % 3) == 0) ? 4 : 3;
        repeat (d - 1) @(posedge clk);
        #1; in_valid = 1'b1; in_left = 8'hA5; in_right = 8'h5A;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sample_tick !== 1'b1 || underrun !== 1'b1)
            $display("FAIL collide_underrun: tick=%b underrun=%b expected 1/1", sample_tick, underrun);
        else passed++;
        d = ((n_ticks % 3) == 0) ? 4 : 3;
        repeat (d) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (sample_tick !== 1'b1 || underrun !== 1'b0 || audio_word !== 16'hA55A)
            $display("FAIL collide_load: tick=%b underrun=%b audio_word=%h expected 1/0/a55a",
                     sample_tick, underrun, audio_word);
        else passed++;
    endtask

    task automatic test_disable_reset();
        logic [2*W-1:0] held;
        int ticks = 0;
        wait_tick("disable_wait");
        checks++;
        if (audio_clk !== 1'b1)
            $display("FAIL aclk_on_tick: audio_clk=%b expected 1", audio_clk);
        else passed++;
        held = audio_word;
        sb_on = 1'b0;
        enable = 1'b0;
        in_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({sample_tick, audio_clk, underrun, in_ready} !== 4'b0000 || audio_word !== held)
            $display("FAIL disable_off: {tick,aclk,underrun,ready}=%b word=%h expected 0000/%h",
                     {sample_tick, audio_clk, underrun, in_ready}, audio_word, held);
        else passed++;
        repeat (12) begin
            @(negedge clk);
            if (sample_tick || audio_clk || in_ready) ticks++;
        end
        checks++;
        if (ticks != 0 || audio_word !== held)
            $display("FAIL off_quiet: activity=%0d word=%h expected 0/%h", ticks, audio_word, held);
        else passed++;
        in_valid = 1'b0;
        #2; rst_n = 1'b0;
        #1;
        checks++;
        if (audio_word !== 16'h0000 || underrun_count !== 16'h0000 ||
            {in_ready, sample_tick, audio_clk, underrun} !== 4'b0000)
            $display("FAIL async_reset: word=%h count=%h flags=%b expected 0000/0000/0000",
                     audio_word, underrun_count, {in_ready, sample_tick, audio_clk, underrun});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_rate();
        int ticks = 0, high = 0, urs = 0, run = 0, bad = 0, guard = 0;
        bit seen_fall = 1'b0;
        @(posedge clk); #1; r_enable = 1'b1; r_in_valid = 1'b1;
        repeat (200) @(posedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (r_sample_tick) ticks++;
            if (r_underrun) urs++;
            if (r_audio_clk) begin
                high++;
                run++;
            end else begin
                if (seen_fall && run != 0 && run != 10) bad++;
                if (run != 0) seen_fall = 1'b1;
                run = 0;
            end
        end
        checks++;
        if (ticks != 48 || urs != 0)
            $display("FAIL rate_ticks: ticks=%0d underruns=%0d expected 48/0", ticks, urs);
        else passed++;
        checks++;
        if (high != 480 || bad != 0)
            $display("FAIL rate_aclk: high_cycles=%0d bad_pulses=%0d expected 480/0", high, bad);
        else passed++;
        // Truncate a pulse part way through.
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!(r_audio_clk && !r_sample_tick) && guard < 50);
        r_enable = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (r_audio_clk !== 1'b0 || r_sample_tick !== 1'b0 || guard >= 50)
            $display("FAIL rate_truncate: audio_clk=%b tick=%b guard=%0d expected 0/0/<50",
                     r_audio_clk, r_sample_tick, guard);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_prime_idle();
        test_stream();
        test_underrun();
        test_collision();
        test_disable_reset();
        test_rate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
